dbus_arb: RTL and testbench
===========================

Name: dbus_arb

Overview:
- Two-master arbiter for the internal data bus feeding the BSC and on-chip peripherals (INTC, DIVU, SCI, FRT, WDT).
- Master 0 is the cache/CPU IBUS path; master 1 is the DMAC bus port.
- Owns grant sequencing, bus-lock holding, priority policy and per-master wait generation.
- Replaces the fixed pass-through so the DMAC and CPU share one slave port with defined fairness.

Parameters:
- RR_DEFAULT, 0, reset value of round-robin enable (0 = fixed priority, DMAC wins).
- TIMEOUT, 255, slave-busy cycle limit for the optional timeout (8-bit counter; legal range 1..255).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1
- RR_EN  in  1  1 = round-robin, 0 = fixed priority (M1 > M0); sampled only in IDLE
- M0_A/M1_A  in  32  master address
- M0_DI/M1_DI  in  32  master write data
- M0_BA/M1_BA  in  4  byte enables
- M0_WE/M1_WE  in  1  write enable
- M0_REQ/M1_REQ  in  1  request (level)
- M0_LOCK/M1_LOCK  in  1  hold the grant across transfers
- M0_WAIT/M1_WAIT  out  1  stall to master
- M_DO  out  32  read data, broadcast to both masters (=S_DI)
- S_A  out  32  slave address
- S_DO  out  32  slave write data
- S_BA  out  4  slave byte enables
- S_WE  out  1  slave write enable
- S_REQ  out  1  slave request
- S_LOCK  out  1  slave lock
- S_BUSY  in  1  slave not ready (combinational from the slave)
- GNT  out  2  one-hot current owner (debug/DMAC ack)

Behaviour:
- Reset: state IDLE, GNT=00, LAST=M0, S_REQ=0, S_WE=0, S_LOCK=0, S_A/S_DO=0, S_BA=0, both WAIT = their REQ (combinational).
- States: IDLE, OWN0, OWN1, TURN.
- IDLE:
  - if only one REQ is high, go to OWNx.
  - if both are high: RR_EN=0 selects M1; RR_EN=1 selects the master opposite LAST.
  - entry takes one CE_R cycle.
- OWNx:
  - S_A/S_DO/S_BA/S_WE/S_LOCK = Mx fields; S_REQ = Mx_REQ; GNT bit x set.
  - Transfer completes on a CE_R cycle with S_REQ=1 and S_BUSY=0. At completion, LAST<=x.
  - After completion:
    - if Mx_LOCK=1, stay in OWNx; the next Mx request issues back-to-back with zero dead cycles.
    - else go to TURN.
  - If Mx_REQ drops with LOCK=0 and no transfer pending, go to TURN.
- TURN: one cycle with S_REQ=0, then IDLE. This guarantees the slave sees a REQ gap between different owners.
- Mx_WAIT = Mx_REQ & ~(GNT[x] & S_REQ & ~S_BUSY). Wait deasserts combinationally in the completion cycle only.
- M_DO is valid in the completion cycle; masters must capture it then.
- Masters hold A/DI/BA/WE stable while WAIT=1. The arbiter does not register the datapath; muxes are driven by the registered GNT.
- Simultaneous events:
  - REQ of the other master arriving at completion is honoured only after TURN (lock permitting).
  - A new RR_EN value is ignored until IDLE.
- Lock starvation: M1 (DMAC) may hold LOCK indefinitely; M0 waits. This is intended for DMA burst/dual-address atomicity.
- RST mid-transfer aborts immediately to reset values. No completion is signalled.
- CE_R=0 freezes state; outputs hold.

Optional Feature:
- Macro DBUS_ARB_TIMEOUT_EN.
- With the macro:
  - adds output TOUT_IRQ (1 bit) and an 8-bit counter.
  - the counter increments every CE_R cycle while S_REQ=1 and S_BUSY=1, and clears on completion or in IDLE.
  - when the counter reaches TIMEOUT:
    - force completion: the owner's WAIT drops for one cycle with M_DO=32'hFFFFFFFF.
    - TOUT_IRQ pulses high for one CE_R cycle.
    - the FSM goes to TURN regardless of LOCK.
- Without the macro: no counter and no port; a stuck S_BUSY stalls the owner forever.

Test Plan:
- M0 read, S_BUSY held 3 cycles:
  - IDLE -> OWN0 in 1 cycle; M0_WAIT high 4 cycles; drops with M_DO=S_DI=32'h12345678.
  - then TURN -> IDLE.
- Both REQ in the same cycle, RR_EN=0, zero-wait slave:
  - M1 granted first (GNT=10); M0 granted after TURN + IDLE (GNT=01 three cycles after M1 completion).
- RR_EN=1, both requesting continuously, 4 transfers:
  - grant order M1, M0, M1, M0 (LAST resets to M0).
- M1_LOCK=1 with 3 back-to-back writes (A=0xFFFFFF80,84,88) while M0_REQ=1:
  - S_REQ never drops between the writes; M0_WAIT stays 1 until TURN after LOCK clears.
- RST asserted during OWN1 with S_BUSY=1:
  - S_REQ=0 and GNT=00 immediately; after release, the pending M0_REQ is granted from IDLE.
- DBUS_ARB_TIMEOUT_EN, TIMEOUT=4, S_BUSY stuck:
  - TOUT_IRQ pulses on the 4th busy cycle; M0 sees M_DO=32'hFFFFFFFF; FSM returns to IDLE.

Source files
------------

// File: rtl/dbus_arb.sv
// -----------------------------------------------------------------------------
// dbus_arb : two-master arbiter for the internal data bus (BSC + peripherals).
//
//   Master 0 = cache/CPU path, master 1 = DMAC port. The arbiter sequences
//   grants through IDLE -> OWNx -> TURN -> IDLE. It holds the grant while the
//   owner asserts LOCK, and it generates a per-master WAIT.
//   The datapath is not registered. The slave-side muxes are steered by the
//   registered one-hot GNT.
//
// Ports:
//   CLK, RST (async, active high), CE_R (state advances only when 1)
//   RR_EN          : 1 = round robin, 0 = fixed priority (M1 wins)
//   Mx_A/DI/BA/WE  : master request fields, held stable while Mx_WAIT=1
//   Mx_REQ/Mx_LOCK : level request / hold grant across transfers
//   Mx_WAIT        : stall to master
//   M_DO           : read data broadcast to both masters
//   S_A/DO/BA/WE/REQ/LOCK : slave side, driven from the current owner
//   S_DI           : slave read data
//   S_BUSY         : slave not ready
//   GNT            : one-hot current owner
//   TOUT_IRQ       : slave-busy timeout pulse (only with DBUS_ARB_TIMEOUT_EN)
//
// Optional feature: define DBUS_ARB_TIMEOUT_EN to add the TIMEOUT parameter,
// the TOUT_IRQ output and an 8-bit busy counter. When the counter expires, it
// forces completion with all-ones read data.
// -----------------------------------------------------------------------------
module dbus_arb #(
  parameter bit RR_DEFAULT = 1'b0
`ifdef DBUS_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        RR_EN,
  input  logic [31:0] M0_A,
  input  logic [31:0] M1_A,
  input  logic [31:0] M0_DI,
  input  logic [31:0] M1_DI,
  input  logic [3:0]  M0_BA,
  input  logic [3:0]  M1_BA,
  input  logic        M0_WE,
  input  logic        M1_WE,
  input  logic        M0_REQ,
  input  logic        M1_REQ,
  input  logic        M0_LOCK,
  input  logic        M1_LOCK,
  output logic        M0_WAIT,
  output logic        M1_WAIT,
  output logic [31:0] M_DO,
  output logic [31:0] S_A,
  output logic [31:0] S_DO,
  output logic [3:0]  S_BA,
  output logic        S_WE,
  output logic        S_REQ,
  output logic        S_LOCK,
  input  logic [31:0] S_DI,
  input  logic        S_BUSY,
`ifdef DBUS_ARB_TIMEOUT_EN
  output logic        TOUT_IRQ,
`endif
  output logic [1:0]  GNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;   // master that completed most recently
  logic       rr_q, rr_d;       // arbitration mode used by the next IDLE decision
  logic       done_s;           // normal completion this cycle
  logic       tout_s;           // forced completion this cycle
  logic       xfer_end_s;

  // Slave-side mux steered by the registered grant; nothing is driven in IDLE/TURN.
  always_comb begin
    S_A    = 32'd0;
    S_DO   = 32'd0;
    S_BA   = 4'd0;
    S_WE   = 1'b0;
    S_REQ  = 1'b0;
    S_LOCK = 1'b0;
    if (gnt_q[1]) begin
      S_A    = M1_A;
      S_DO   = M1_DI;
      S_BA   = M1_BA;
      S_WE   = M1_WE;
      S_REQ  = M1_REQ;
      S_LOCK = M1_LOCK;
    end else if (gnt_q[0]) begin
      S_A    = M0_A;
      S_DO   = M0_DI;
      S_BA   = M0_BA;
      S_WE   = M0_WE;
      S_REQ  = M0_REQ;
      S_LOCK = M0_LOCK;
    end else begin
      S_A    = 32'd0;
      S_DO   = 32'd0;
      S_BA   = 4'd0;
      S_WE   = 1'b0;
      S_REQ  = 1'b0;
      S_LOCK = 1'b0;
    end
  end

  assign done_s     = S_REQ & ~S_BUSY;
  assign xfer_end_s = done_s | tout_s;

  // WAIT follows REQ and drops only in the owner's completion cycle.
  assign M0_WAIT = M0_REQ & ~(gnt_q[0] & xfer_end_s);
  assign M1_WAIT = M1_REQ & ~(gnt_q[1] & xfer_end_s);
  assign M_DO    = tout_s ? 32'hFFFF_FFFF : S_DI;
  assign GNT     = gnt_q;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 32'd1);

  logic [7:0] tcnt_q, tcnt_d;

  // The limit is hit in the busy cycle that would be the TIMEOUT-th one.
  assign tout_s   = S_REQ & S_BUSY & (tcnt_q == TOUT_LAST);
  assign TOUT_IRQ = tout_s;

  // Busy-cycle counter next state.
  always_comb begin
    tcnt_d = tcnt_q;
    if ((state_q == ST_IDLE) || done_s || tout_s) begin
      tcnt_d = 8'd0;
    end else if (S_REQ && S_BUSY) begin
      tcnt_d = tcnt_q + 8'd1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt_q <= 8'd0;
    end else if (CE_R) begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign tout_s = 1'b0;
`endif

  // Grant sequencing next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        rr_d = RR_EN;
        // M1 wins a tie under fixed priority, or under round robin when M0 went last.
        if (M1_REQ && (!M0_REQ || !rr_q || !last_q)) begin
          state_d = ST_OWN1;
          gnt_d   = 2'b10;
        end else if (M0_REQ) begin
          state_d = ST_OWN0;
          gnt_d   = 2'b01;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (tout_s) begin
          // A forced completion always releases the bus, lock or not.
          last_d  = (state_q == ST_OWN1);
          state_d = ST_TURN;
          gnt_d   = 2'b00;
        end else if (done_s) begin
          last_d = (state_q == ST_OWN1);
          if (S_LOCK) begin
            state_d = state_q;
            gnt_d   = gnt_q;
          end else begin
            state_d = ST_TURN;
            gnt_d   = 2'b00;
          end
        end else if (!S_REQ && !S_LOCK) begin
          state_d = ST_TURN;
          gnt_d   = 2'b00;
        end else begin
          state_d = state_q;
          gnt_d   = gnt_q;
        end
      end
      ST_TURN: begin
        // The mode is refreshed only between ownerships.
        rr_d    = RR_EN;
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // FSM and registered grant; CE_R=0 freezes everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b0;
      rr_q    <= RR_DEFAULT;
    end else if (CE_R) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_dbus_arb.sv
module tb_dbus_arb;

  logic        CLK = 1'b0;
  logic        RST, CE_R, RR_EN;
  logic [31:0] M0_A, M1_A, M0_DI, M1_DI, S_DI;
  logic [3:0]  M0_BA, M1_BA;
  logic        M0_WE, M1_WE, M0_REQ, M1_REQ, M0_LOCK, M1_LOCK, S_BUSY;
  logic        M0_WAIT, M1_WAIT, S_WE, S_REQ, S_LOCK;
  logic [31:0] M_DO, S_A, S_DO;
  logic [3:0]  S_BA;
  logic [1:0]  GNT;
`ifdef DBUS_ARB_TIMEOUT_EN
  logic        TOUT_IRQ;
  logic        tout_seen;
`endif

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct {
    int          m;
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  dbus_arb #(
    .RR_DEFAULT(1'b0)
`ifdef DBUS_ARB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .RR_EN(RR_EN),
    .M0_A(M0_A), .M1_A(M1_A), .M0_DI(M0_DI), .M1_DI(M1_DI),
    .M0_BA(M0_BA), .M1_BA(M1_BA), .M0_WE(M0_WE), .M1_WE(M1_WE),
    .M0_REQ(M0_REQ), .M1_REQ(M1_REQ), .M0_LOCK(M0_LOCK), .M1_LOCK(M1_LOCK),
    .M0_WAIT(M0_WAIT), .M1_WAIT(M1_WAIT), .M_DO(M_DO),
    .S_A(S_A), .S_DO(S_DO), .S_BA(S_BA), .S_WE(S_WE), .S_REQ(S_REQ),
    .S_LOCK(S_LOCK), .S_DI(S_DI), .S_BUSY(S_BUSY),
`ifdef DBUS_ARB_TIMEOUT_EN
    .TOUT_IRQ(TOUT_IRQ),
`endif
    .GNT(GNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int m, input logic [31:0] a, input logic we, input logic [31:0] d);
    exp_t e;
    e.m = m; e.a = a; e.we = we; e.d = d;
    sb.push_back(e);
  endtask

  // Runs cycles until a master sees its WAIT drop, with a slave that stays
  // busy for 'busy' requested cycles; checks the completion against the
  // scoreboard head and returns one cycle after completion.
  task automatic wait_cmp(input int busy, output int waits, output int done_cyc);
    int   b;
    bit   done;
    int   who;
    exp_t e;
    b = busy; done = 1'b0; waits = 0; done_cyc = -1;
    for (int i = 0; i < 64 && !done; i++) begin
      S_BUSY = (b > 0);
      #1;
      if ((M0_REQ && !M0_WAIT) || (M1_REQ && !M1_WAIT)) begin
        done     = 1'b1;
        done_cyc = cyc_n;
        who      = (M1_REQ && !M1_WAIT) ? 1 : 0;
`ifdef DBUS_ARB_TIMEOUT_EN
        tout_seen = TOUT_IRQ;
`endif
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("owner", 32'(who), 32'(e.m));
          chk("gnt", 32'(GNT), 32'(2'b01 << e.m));
          chk("s_a", S_A, e.a);
          chk("s_we", 32'(S_WE), 32'(e.we));
          if (e.we) chk("s_do", S_DO, e.d);
          else      chk("m_do", M_DO, e.d);
        end
      end else begin
        if (M0_WAIT || M1_WAIT) waits++;
        if (S_REQ && S_BUSY && b > 0) b--;
      end
      tick();
    end
    S_BUSY = 1'b0;
    chk("xfer_done", 32'(done), 32'd1);
  endtask

  initial begin
    int w, c1, c2;
    RST = 1'b1; CE_R = 1'b1; RR_EN = 1'b0; S_BUSY = 1'b0; S_DI = 32'd0;
    M0_A = 32'd0; M1_A = 32'd0; M0_DI = 32'd0; M1_DI = 32'd0;
    M0_BA = 4'hF; M1_BA = 4'hF; M0_WE = 1'b0; M1_WE = 1'b0;
    M0_REQ = 1'b1; M1_REQ = 1'b0; M0_LOCK = 1'b0; M1_LOCK = 1'b0;

    // Reset values; WAIT mirrors REQ while no grant exists.
    tick();
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_sreq", 32'(S_REQ), 32'd0);
    chk("rst_sa", S_A, 32'd0);
    chk("rst_sdo", S_DO, 32'd0);
    chk("rst_sba", 32'(S_BA), 32'd0);
    chk("rst_swe", 32'(S_WE), 32'd0);
    chk("rst_slock", 32'(S_LOCK), 32'd0);
    chk("rst_m0wait", 32'(M0_WAIT), 32'd1);
    chk("rst_m1wait", 32'(M1_WAIT), 32'd0);
    M0_REQ = 1'b0;
    tick();
    RST = 1'b0;
    tick();

    // M0 read, slave busy for 3 cycles.
    M0_A = 32'h0000_0100; S_DI = 32'h1234_5678; M0_REQ = 1'b1;
    push(0, 32'h0000_0100, 1'b0, 32'h1234_5678);
    #1;
    chk("t1_idle_gnt", 32'(GNT), 32'd0);
    wait_cmp(3, w, c1);
    chk("t1_waits", 32'(w), 32'd4);
    M0_REQ = 1'b0;
    #1;
    chk("t1_turn_gnt", 32'(GNT), 32'd0);
    chk("t1_turn_sreq", 32'(S_REQ), 32'd0);
    tick();

    // Simultaneous requests, fixed priority, zero-wait slave.
    M0_A = 32'h0000_0200; M1_A = 32'h0000_0300; S_DI = 32'hCAFE_0001;
    M0_REQ = 1'b1; M1_REQ = 1'b1;
    push(1, 32'h0000_0300, 1'b0, 32'hCAFE_0001);
    push(0, 32'h0000_0200, 1'b0, 32'hCAFE_0001);
    wait_cmp(0, w, c1);
    M1_REQ = 1'b0;
    #1;
    chk("t2_turn_gnt", 32'(GNT), 32'd0);
    chk("t2_m0wait", 32'(M0_WAIT), 32'd1);
    wait_cmp(0, w, c2);
    chk("t2_gap", 32'(c2 - c1), 32'd3);
    M0_REQ = 1'b0;
    tick();

    // Round robin, both requesting continuously.
    RR_EN = 1'b1;
    tick();
    M0_A = 32'h0000_0500; M1_A = 32'h0000_0600; S_DI = 32'hBEEF_0002;
    M0_REQ = 1'b1; M1_REQ = 1'b1;
    push(1, 32'h0000_0600, 1'b0, 32'hBEEF_0002);
    push(0, 32'h0000_0500, 1'b0, 32'hBEEF_0002);
    push(1, 32'h0000_0600, 1'b0, 32'hBEEF_0002);
    push(0, 32'h0000_0500, 1'b0, 32'hBEEF_0002);
    for (int i = 0; i < 4; i++) wait_cmp(i, w, c1);
    M0_REQ = 1'b0; M1_REQ = 1'b0; RR_EN = 1'b0;
    tick();
    tick();

    // Locked DMAC burst of three writes while M0 is requesting.
    M1_A = 32'hFFFF_FF80; M1_DI = 32'h0000_0011; M1_WE = 1'b1; M1_BA = 4'h3;
    M1_LOCK = 1'b1; M1_REQ = 1'b1;
    M0_A = 32'h0000_0700; M0_REQ = 1'b1; S_DI = 32'h5A5A_0003;
    push(1, 32'hFFFF_FF80, 1'b1, 32'h0000_0011);
    push(1, 32'hFFFF_FF84, 1'b1, 32'h0000_0022);
    push(1, 32'hFFFF_FF88, 1'b1, 32'h0000_0033);
    push(0, 32'h0000_0700, 1'b0, 32'h5A5A_0003);
    wait_cmp(1, w, c1);
    M1_A = 32'hFFFF_FF84; M1_DI = 32'h0000_0022;
    #1;
    chk("t4_sreq_b2b1", 32'(S_REQ), 32'd1);
    chk("t4_slock", 32'(S_LOCK), 32'd1);
    chk("t4_sba", 32'(S_BA), 32'h3);
    chk("t4_m0wait1", 32'(M0_WAIT), 32'd1);
    wait_cmp(0, w, c1);
    M1_A = 32'hFFFF_FF88; M1_DI = 32'h0000_0033; M1_LOCK = 1'b0;
    #1;
    chk("t4_sreq_b2b2", 32'(S_REQ), 32'd1);
    chk("t4_m0wait2", 32'(M0_WAIT), 32'd1);
    wait_cmp(0, w, c1);
    M1_REQ = 1'b0; M1_WE = 1'b0;
    #1;
    chk("t4_turn_sreq", 32'(S_REQ), 32'd0);
    chk("t4_m0wait3", 32'(M0_WAIT), 32'd1);
    wait_cmp(0, w, c1);
    M0_REQ = 1'b0;
    tick();

    // Reset during a busy M1 transfer; pending M0 request survives.
    M1_A = 32'h0000_0800; M0_A = 32'h0000_0900;
    M1_REQ = 1'b1; M0_REQ = 1'b1; S_BUSY = 1'b1;
    tick();
    chk("t5_own1_gnt", 32'(GNT), 32'd2);
    chk("t5_own1_sreq", 32'(S_REQ), 32'd1);
    RST = 1'b1;
    #1;
    chk("t5_rst_sreq", 32'(S_REQ), 32'd0);
    chk("t5_rst_gnt", 32'(GNT), 32'd0);
    chk("t5_rst_sa", S_A, 32'd0);
    tick();
    RST = 1'b0; M1_REQ = 1'b0; S_DI = 32'h0F0F_0004;
    push(0, 32'h0000_0900, 1'b0, 32'h0F0F_0004);
    wait_cmp(0, w, c1);
    M0_REQ = 1'b0;
    tick();

    // CE_R low freezes the FSM in IDLE.
    M0_A = 32'h0000_0A00; M0_REQ = 1'b1; CE_R = 1'b0; S_DI = 32'h2222_0005;
    tick();
    tick();
    chk("t6_frozen_gnt", 32'(GNT), 32'd0);
    chk("t6_frozen_wait", 32'(M0_WAIT), 32'd1);
    CE_R = 1'b1;
    push(0, 32'h0000_0A00, 1'b0, 32'h2222_0005);
    wait_cmp(0, w, c1);
    chk("t6_waits", 32'(w), 32'd1);
    M0_REQ = 1'b0;
    tick();

`ifdef DBUS_ARB_TIMEOUT_EN
    // Stuck slave: forced completion on the 4th busy cycle, even with LOCK set.
    M0_A = 32'h0000_0B00; M0_LOCK = 1'b1; M0_REQ = 1'b1; S_DI = 32'h1357_2468;
    tout_seen = 1'b0;
    push(0, 32'h0000_0B00, 1'b0, 32'hFFFF_FFFF);
    wait_cmp(100, w, c1);
    chk("t7_waits", 32'(w), 32'd4);
    chk("t7_irq", 32'(tout_seen), 32'd1);
    #1;
    chk("t7_turn_gnt", 32'(GNT), 32'd0);
    chk("t7_irq_pulse", 32'(TOUT_IRQ), 32'd0);
    M0_REQ = 1'b0; M0_LOCK = 1'b0;
    tick();
    chk("t7_idle_gnt", 32'(GNT), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
